nes_attr_fetch: RTL

NES_ATTR_FETCH -- requirements
Module: nes_attr_fetch

---
 rtl/nes_ppu_pkg.sv | 15 +
 rtl/attr_quad_sel.sv | 14 +
 rtl/nes_attr_fetch.sv | 127 ++++++++++++
 3 files changed

// File: rtl/nes_ppu_pkg.sv
// Shared PPU constants and the attribute-fetch FSM encoding.
package nes_ppu_pkg;

  localparam int unsigned ATABLE_AW          = 7;
  localparam int unsigned ATTR_BYTES_PER_ROW = 8;
  localparam int unsigned TILE_IDX_W         = 5;
  localparam int unsigned ATTR_CNT_W         = $clog2(ATTR_BYTES_PER_ROW);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StReady = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/attr_quad_sel.sv
// Picks the 2-bit palette field of one quadrant out of an attribute byte.
// Quadrant layout: 0 = TL [1:0], 1 = TR [3:2], 2 = BL [5:4], 3 = BR [7:6].
module attr_quad_sel (
  input  logic [7:0] attr_byte,
  input  logic [1:0] q,
  output logic [1:0] sel
);

  // Select the field at bit offset 2*q.
  always_comb begin
    sel = attr_byte[{q, 1'b0} +: 2];
  end

endmodule

// File: rtl/nes_attr_fetch.sv
// Fetches one attribute row (8 bytes) from an external combinational ROM into a
// local buffer, then serves per-tile palette lookups from that buffer.
module nes_attr_fetch
  import nes_ppu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  row_start,
  input  logic [TILE_IDX_W-1:0] tile_row,
  input  logic                  nt_sel,
  output logic [ATABLE_AW-1:0]  atable_addr,
  input  logic [7:0]            atable_dout,
  output logic                  ready,
  output logic                  fetch_done,
  input  logic                  lkp_req,
  input  logic [TILE_IDX_W-1:0] tile_col,
  output logic [1:0]            pal_sel,
  output logic                  pal_vld
);

  fetch_state_e state_q, state_d;

  logic [ATTR_CNT_W-1:0] cnt_q, cnt_d;
  logic [TILE_IDX_W-1:0] row_q;
  logic                  nt_q;
  logic [7:0]            attr_buf_q [ATTR_BYTES_PER_ROW];
  logic                  done_q;
  logic                  pal_vld_q;
  logic [1:0]            pal_sel_q;

  logic       store_en;
  logic       fetch_last;
  logic [7:0] lkp_byte;
  logic [1:0] lkp_quad;
  logic [1:0] lkp_sel;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a row_start restarts the fetch from any state, aborting a running one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  state_d = StIdle;
      StFetch: if (cnt_q == ATTR_CNT_W'(ATTR_BYTES_PER_ROW - 1)) state_d = StReady;
      StReady: state_d = StReady;
      default: state_d = StIdle;
    endcase
    if (row_start) state_d = StFetch;
  end

  // FSM outputs and byte counter; an aborted fetch stores nothing in its last cycle.
  always_comb begin
    ready      = (state_q == StReady);
    store_en   = (state_q == StFetch) && !row_start;
    fetch_last = store_en && (cnt_q == ATTR_CNT_W'(ATTR_BYTES_PER_ROW - 1));
    cnt_d      = cnt_q;
    if (row_start) begin
      cnt_d = '0;
    end else if (store_en) begin
      cnt_d = cnt_q + 1'b1;  // wraps to 0 after the last byte
    end
  end

  // Row latch, byte buffer and fetch_done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      row_q  <= '0;
      nt_q   <= 1'b0;
      done_q <= 1'b0;
      for (int i = 0; i < ATTR_BYTES_PER_ROW; i++) begin
        attr_buf_q[i] <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      done_q <= fetch_last;
      if (row_start) begin
        row_q <= tile_row;
        nt_q  <= nt_sel;
      end
      if (store_en) begin
        attr_buf_q[cnt_q] <= atable_dout;
      end
    end
  end

  assign atable_addr = {nt_q, row_q[4:2], cnt_q};
  assign fetch_done  = done_q;

  // Lookup path: byte by column group, quadrant from row/column bit 1.
  assign lkp_byte = attr_buf_q[tile_col[4:2]];
  assign lkp_quad = {row_q[1], tile_col[1]};

  attr_quad_sel u_quad_sel (
    .attr_byte (lkp_byte),
    .q         (lkp_quad),
    .sel       (lkp_sel)
  );

  // Registered lookup result; pal_sel holds when a request is not served.
  always_ff @(posedge clk) begin
    if (rst) begin
      pal_vld_q <= 1'b0;
      pal_sel_q <= '0;
    end else begin
      pal_vld_q <= lkp_req && ready;
      if (lkp_req && ready) begin
        pal_sel_q <= lkp_sel;
      end
    end
  end

  assign pal_vld = pal_vld_q;
  assign pal_sel = pal_sel_q;

  // Bit 0 of row and column does not affect the attribute quadrant.
  logic unused_idx_bits;
  assign unused_idx_bits = ^{row_q[0], tile_col[0]};

endmodule
